lcd_cmd_sched: RTL and testbench
================================

# lcd_cmd_sched

Command scheduler in front of the LCD image controller. It accepts image-processing commands from two independent requesters (host and on-chip script sequencer) over valid/ready handshakes and arbitrates between them round-robin. It issues exactly one command at a time to the LCD controller, pacing on its `busy`, and filters illegal opcodes. It locks out all traffic once the terminal write command has been issued and the controller reports `done`.

## Interface
Parameters:
- `CNT_W`, default 8: width of the issued/dropped command counters (saturating).
- `BUSY_TO`, default 15: maximum number of cycles to wait for `lcd_busy` to rise after an issue.

Ports:
- `clk` in 1: single clock; all state changes on posedge.
- `reset` in 1: asynchronous, active-low reset.
- `req0_valid` / `req0_cmd` in 1/4: requester 0 command offer.
- `req0_ready` out 1: requester 0 transfer accept.
- `req1_valid` / `req1_cmd` in 1/4: requester 1 command offer.
- `req1_ready` out 1: requester 1 transfer accept.
- `lcd_cmd` out 4: command to the LCD controller.
- `lcd_cmd_valid` out 1: one-cycle issue strobe.
- `lcd_busy` in 1: LCD controller busy (loading, operating or writing).
- `lcd_done` in 1: LCD controller finished writing the image.
- `grant_id` out 1: requester of the most recently accepted legal command.
- `issued_cnt` out CNT_W: legal commands issued.
- `drop_cnt` out CNT_W: illegal commands accepted and discarded.
- `timeout_err` out 1: sticky; set when busy failed to rise within BUSY_TO cycles.
- `all_done` out 1: terminal state reached.

## Operation
- Opcodes: 0 = WRITE (terminal); 1–11 = legal operations; 12–15 = illegal.
- States: INIT, ARB, ISSUE, WAIT_BUSY, WAIT_IDLE, FINISH, DONE.
- INIT: wait for `lcd_busy`==0 at a posedge (image load complete), then go to ARB.
- ARB: the winner is the only valid requester, or on a tie the requester that was *not* last granted (`last` resets to 1, so req0 wins the first tie).
  - `reqN_ready` = (state==ARB) && winner==N. It is combinational and never high for both requesters.
  - A transfer occurs when valid && ready. If no request is valid, stay in ARB.
  - Illegal opcode: drop it, increment `drop_cnt`, update `last`, stay in ARB.
  - Legal opcode: latch it into `lcd_cmd`, update `grant_id` and `last`, go to ISSUE.
- ISSUE: assert `lcd_cmd_valid` for exactly this cycle and increment `issued_cnt`. Go to FINISH if the opcode is 0, else to WAIT_BUSY.
- WAIT_BUSY: go to WAIT_IDLE when `lcd_busy`==1. If BUSY_TO cycles elapse without it, set `timeout_err` and return to ARB.
- WAIT_IDLE: return to ARB when `lcd_busy`==0.
- FINISH: go to DONE when `lcd_done`==1.
- DONE: `all_done`=1. Both readies stay low and requests are ignored until reset.
- Counters saturate at 2^CNT_W−1 and do not wrap.
- Reset values: state INIT, all readies 0, `lcd_cmd`=0, `lcd_cmd_valid`=0, `grant_id`=0, both counters 0, `timeout_err`=0, `all_done`=0, `last`=1.

## Timing
- Transfer at posedge t (in ARB) → `lcd_cmd_valid`=1 during cycle t+1 → WAIT_BUSY from t+2.
- `lcd_cmd` is held stable from t+1 until the next legal transfer.
- Minimum spacing between two issues is 4 cycles: ISSUE, WAIT_BUSY, WAIT_IDLE, ARB.
- Illegal-command drops sustain one transfer per cycle.
- Assertion of `reset` mid-operation clears all state immediately, including during an active `lcd_cmd_valid`. Nothing in flight is retried.
- Requests offered during ISSUE/WAIT_*/FINISH must remain held by the requester. The requester must not change `reqN_cmd` while valid and not ready.
- A WRITE issued while the other requester is pending leaves that requester unserved forever; this is the required behaviour.
- The timeout counter is BUSY_TO-sized. It is cleared on entry to WAIT_BUSY.

## Structure
- Shared package `lcd_pkg`:
  - opcode localparams CMD_WRITE=0 … CMD_MIRROR_Y=11, CMD_MAX_LEGAL=11;
  - the state encoding;
  - `is_legal_cmd` function.
- One sub-module `rr_arb2`: two-input round-robin arbiter. Inputs: valids, `last`. Output: winner and any-valid.
- Top-level content: FSM, latches, counters, timeout.

## Test plan
- Reset release with `lcd_busy` high for 64 cycles, then low → ARB entered; no ready seen before busy falls.
- req0 `cmd`=3, LCD model busy 3 cycles → `lcd_cmd`=3, one-cycle `lcd_cmd_valid` at t+1, `issued_cnt`=1, `grant_id`=0, next ready only after busy falls.
- Both valid continuously (req0=1, req1=5) → issue order 1,5,1,5; `grant_id` alternates 0,1,0,1.
- req1 offers 13, 15, then 7 → `drop_cnt`=2 after two consecutive cycles; 7 issued; `issued_cnt`=1.
- LCD model never raises busy after an issue → after 15 cycles `timeout_err`=1 (sticky); next command is still accepted.
- req0 WRITE while req1 pending, `lcd_done` 10 cycles later → FINISH then `all_done`=1; `req1_ready` never asserted. Assert `reset` low → all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command scheduler: opcodes, FSM encoding
// and the opcode legality check.
package lcd_pkg;

  localparam logic [3:0] CMD_WRITE     = 4'd0;
  localparam logic [3:0] CMD_INVERT    = 4'd1;
  localparam logic [3:0] CMD_BRIGHT_UP = 4'd2;
  localparam logic [3:0] CMD_BRIGHT_DN = 4'd3;
  localparam logic [3:0] CMD_THRESH    = 4'd4;
  localparam logic [3:0] CMD_BLUR      = 4'd5;
  localparam logic [3:0] CMD_SHARPEN   = 4'd6;
  localparam logic [3:0] CMD_ROT_L     = 4'd7;
  localparam logic [3:0] CMD_ROT_R     = 4'd8;
  localparam logic [3:0] CMD_ZOOM      = 4'd9;
  localparam logic [3:0] CMD_MIRROR_X  = 4'd10;
  localparam logic [3:0] CMD_MIRROR_Y  = 4'd11;
  localparam logic [3:0] CMD_MAX_LEGAL = 4'd11;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_ARB       = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_IDLE = 3'd4,
    ST_FINISH    = 3'd5,
    ST_DONE      = 3'd6
  } sched_state_t;

  function automatic logic is_legal_cmd(input logic [3:0] cmd);
    return (cmd <= CMD_MAX_LEGAL);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: a lone requester wins outright, a tie goes
// to the requester that was not granted last.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic       winner,
  output logic       any_valid
);

  // winner selection from the valid pattern and the previous grant
  always_comb begin
    any_valid = valid[0] | valid[1];
    winner    = 1'b0;
    case (valid)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/lcd_cmd_sched.sv
// Schedules commands from two requesters onto the LCD controller one at a
// time, pacing on lcd_busy, dropping illegal opcodes and locking after WRITE.
module lcd_cmd_sched
  import lcd_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int BUSY_TO = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [3:0]       req0_cmd,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [3:0]       req1_cmd,
  output logic             req1_ready,
  output logic [3:0]       lcd_cmd,
  output logic             lcd_cmd_valid,
  input  logic             lcd_busy,
  input  logic             lcd_done,
  output logic             grant_id,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             timeout_err,
  output logic             all_done
);

  localparam int              TO_W    = $clog2(BUSY_TO + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TO - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);

  sched_state_t    state_r, state_nxt_s;
  logic            last_r;
  logic [TO_W-1:0] to_cnt_r;
  logic            winner_s, any_valid_s, xfer_s, win_legal_s, to_hit_s;
  logic [3:0]      win_cmd_s;

  rr_arb2 u_arb (
    .valid     ({req1_valid, req0_valid}),
    .last      (last_r),
    .winner    (winner_s),
    .any_valid (any_valid_s)
  );

  // handshake decode: only the arbitration winner sees ready, and only in ARB
  always_comb begin
    xfer_s      = (state_r == ST_ARB) && any_valid_s;
    req0_ready  = xfer_s && !winner_s;
    req1_ready  = xfer_s && winner_s;
    win_cmd_s   = winner_s ? req1_cmd : req0_cmd;
    win_legal_s = is_legal_cmd(win_cmd_s);
    to_hit_s    = (to_cnt_r == TO_LAST) && !lcd_busy;
  end

  // next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT:      if (!lcd_busy) state_nxt_s = ST_ARB; else state_nxt_s = ST_INIT;
      ST_ARB:       if (xfer_s && win_legal_s) state_nxt_s = ST_ISSUE; else state_nxt_s = ST_ARB;
      ST_ISSUE:     if (lcd_cmd == CMD_WRITE) state_nxt_s = ST_FINISH; else state_nxt_s = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (lcd_busy)      state_nxt_s = ST_WAIT_IDLE;
        else if (to_hit_s) state_nxt_s = ST_ARB;
        else               state_nxt_s = ST_WAIT_BUSY;
      end
      ST_WAIT_IDLE: if (!lcd_busy) state_nxt_s = ST_ARB; else state_nxt_s = ST_WAIT_IDLE;
      ST_FINISH:    if (lcd_done) state_nxt_s = ST_DONE; else state_nxt_s = ST_FINISH;
      ST_DONE:      state_nxt_s = ST_DONE;
      default:      state_nxt_s = ST_INIT;
    endcase
  end

  // state register plus the strobes decoded from the upcoming state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_INIT;
      lcd_cmd_valid <= 1'b0;
      all_done      <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      lcd_cmd_valid <= (state_nxt_s == ST_ISSUE);
      all_done      <= (state_nxt_s == ST_DONE);
    end
  end

  // grant bookkeeping: drops move the round-robin pointer but not grant_id
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_r   <= 1'b1;
      lcd_cmd  <= 4'd0;
      grant_id <= 1'b0;
    end else if (xfer_s) begin
      last_r <= winner_s;
      if (win_legal_s) begin
        lcd_cmd  <= win_cmd_s;
        grant_id <= winner_s;
      end
    end
  end

  // saturating issue/drop counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issued_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if ((state_r == ST_ISSUE) && (issued_cnt != CNT_MAX))
        issued_cnt <= issued_cnt + CNT_ONE;
      if (xfer_s && !win_legal_s && (drop_cnt != CNT_MAX))
        drop_cnt <= drop_cnt + CNT_ONE;
    end
  end

  // busy-rise watchdog; cleared while issuing so each WAIT_BUSY starts at 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_r    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_r == ST_ISSUE)
        to_cnt_r <= '0;
      else if ((state_r == ST_WAIT_BUSY) && !to_hit_s)
        to_cnt_r <= to_cnt_r + TO_ONE;
      if ((state_r == ST_WAIT_BUSY) && to_hit_s)
        timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Directed bench for lcd_cmd_sched with a transaction-level reference model
// checked every cycle, plus hand-computed expectations per scenario.
module tb_lcd_cmd_sched;

  localparam int CW   = 8;
  localparam int BTO  = 15;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0]    req0_cmd = 4'd0, req1_cmd = 4'd0;
  logic          req0_ready, req1_ready;
  logic [3:0]    lcd_cmd;
  logic          lcd_cmd_valid;
  logic          lcd_busy = 1'b1;
  logic          lcd_done = 1'b0;
  logic          grant_id;
  logic [CW-1:0] issued_cnt, drop_cnt;
  logic          timeout_err, all_done;

  lcd_cmd_sched #(.CNT_W(CW), .BUSY_TO(BTO)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_ready(req1_ready),
    .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid),
    .lcd_busy(lcd_busy), .lcd_done(lcd_done), .grant_id(grant_id),
    .issued_cnt(issued_cnt), .drop_cnt(drop_cnt),
    .timeout_err(timeout_err), .all_done(all_done)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- LCD controller responder ----------------
  bit force_busy = 1'b1;
  int busy_len = 3;
  int busy_left = 0;

  initial forever begin
    @(negedge clk);
    if (force_busy) lcd_busy = 1'b1;
    else if (lcd_cmd_valid && busy_len > 0) begin
      lcd_busy = 1'b1;
      busy_left = busy_len;
    end else if (busy_left > 1) busy_left--;
    else begin
      lcd_busy = 1'b0;
      busy_left = 0;
    end
  end

  // ---------------- reference model ----------------
  // A session: boot until the panel is idle, then accept offers; a legal
  // offer is strobed next cycle, then the panel must rise within BTO cycles
  // and fall again before the next offer; WRITE waits for done, then locks.
  bit m_boot = 1, m_accept = 0, m_strobe = 0, m_wfall = 0, m_wdone = 0;
  bit m_done = 0, m_terr = 0;
  int m_rise = 0, m_last = 1, m_grant = 0, m_cmd = 0, m_issued = 0, m_drop = 0;

  function automatic int pick(input bit v0, input bit v1, input int last);
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
    return (last == 0) ? 1 : 0;
  endfunction

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_boot = 1; m_accept = 0; m_strobe = 0; m_wfall = 0; m_wdone = 0;
      m_done = 0; m_terr = 0; m_rise = 0; m_last = 1; m_grant = 0;
      m_cmd = 0; m_issued = 0; m_drop = 0;
    end else if (m_done) begin
      m_done = 1;
    end else if (m_boot) begin
      if (!lcd_busy) begin m_boot = 0; m_accept = 1; end
    end else if (m_accept) begin
      if (req0_valid || req1_valid) begin
        int w, c;
        w = pick(req0_valid, req1_valid, m_last);
        c = (w == 1) ? int'(req1_cmd) : int'(req0_cmd);
        m_last = w;
        if (c >= 12) m_drop = (m_drop < MAXC) ? m_drop + 1 : MAXC;
        else begin
          m_cmd = c; m_grant = w; m_accept = 0; m_strobe = 1;
        end
      end
    end else if (m_strobe) begin
      m_strobe = 0;
      m_issued = (m_issued < MAXC) ? m_issued + 1 : MAXC;
      if (m_cmd == 0) m_wdone = 1; else m_rise = BTO;
    end else if (m_rise > 0) begin
      if (lcd_busy) begin m_rise = 0; m_wfall = 1; end
      else begin
        m_rise--;
        if (m_rise == 0) begin m_terr = 1; m_accept = 1; end
      end
    end else if (m_wfall) begin
      if (!lcd_busy) begin m_wfall = 0; m_accept = 1; end
    end else if (m_wdone) begin
      if (lcd_done) begin m_wdone = 0; m_done = 1; end
    end
  end

  // ---------------- per-cycle compare + monitors ----------------
  int rdy_seen = 0, r1_seen = 0;
  int q_cmd[$], q_gnt[$];

  initial forever begin
    int w;
    bit anyv;
    @(negedge clk);
    anyv = req0_valid || req1_valid;
    w = pick(req0_valid, req1_valid, m_last);
    chk("req0_ready", int'(req0_ready), int'(m_accept && anyv && w == 0));
    chk("req1_ready", int'(req1_ready), int'(m_accept && anyv && w == 1));
    chk("lcd_cmd_valid", int'(lcd_cmd_valid), int'(m_strobe));
    chk("lcd_cmd", int'(lcd_cmd), m_cmd);
    chk("grant_id", int'(grant_id), m_grant);
    chk("issued_cnt", int'(issued_cnt), m_issued);
    chk("drop_cnt", int'(drop_cnt), m_drop);
    chk("timeout_err", int'(timeout_err), int'(m_terr));
    chk("all_done", int'(all_done), int'(m_done));
    if (req0_ready || req1_ready) rdy_seen++;
    if (req1_ready) r1_seen++;
    if (lcd_cmd_valid) begin q_cmd.push_back(int'(lcd_cmd)); q_gnt.push_back(int'(grant_id)); end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic offer(input int who, input logic [3:0] cmd);
    bit got = 1'b0;
    if (who == 0) begin req0_valid = 1'b1; req0_cmd = cmd; end
    else          begin req1_valid = 1'b1; req1_cmd = cmd; end
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if ((who == 0 && req0_ready) || (who == 1 && req1_ready)) got = 1'b1;
    end
    @(posedge clk); #1;
    if (who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    chk("offer_accepted", int'(got), 1);
  endtask

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0; lcd_done = 1'b0; force_busy = 1'b0;
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    int base, k, r0, r1b;
    int exp_c[4], exp_g[4];
    exp_c[0] = 1; exp_c[1] = 5; exp_c[2] = 1; exp_c[3] = 5;
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;

    // boot: busy held high for 64 cycles with a request already offered
    repeat (3) tick();
    chk("reset_issued", int'(issued_cnt), 0);
    chk("reset_ready0", int'(req0_ready), 0);
    reset = 1'b1;
    r0 = rdy_seen;
    req0_valid = 1'b1; req0_cmd = 4'd2;
    repeat (64) tick();
    chk("boot_no_ready", rdy_seen, r0);
    force_busy = 1'b0;
    offer(0, 4'd2);
    chk("boot_first_strobe", int'(lcd_cmd_valid), 1);
    repeat (10) tick();

    // single legal command, 3-cycle busy
    do_reset();
    busy_len = 3;
    offer(0, 4'd3);
    chk("t2_strobe_hi", int'(lcd_cmd_valid), 1);
    chk("t2_cmd", int'(lcd_cmd), 3);
    chk("t2_grant", int'(grant_id), 0);
    tick();
    chk("t2_strobe_lo", int'(lcd_cmd_valid), 0);
    chk("t2_issued", int'(issued_cnt), 1);
    repeat (8) tick();

    // both requesters valid continuously: strict alternation
    do_reset();
    base = q_cmd.size();
    req0_valid = 1'b1; req0_cmd = 4'd1;
    req1_valid = 1'b1; req1_cmd = 4'd5;
    k = 0;
    while (q_cmd.size() < base + 4 && k < 200) begin tick(); k++; end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t3_four_issues", int'(q_cmd.size() >= base + 4), 1);
    for (int i = 0; i < 4; i++) begin
      if (q_cmd.size() > base + i) begin
        chk("t3_order_cmd", q_cmd[base + i], exp_c[i]);
        chk("t3_order_grant", q_gnt[base + i], exp_g[i]);
      end
    end
    repeat (8) tick();

    // illegal drops back to back, then a legal one
    do_reset();
    offer(1, 4'd13);
    chk("t4_drop1", int'(drop_cnt), 1);
    offer(1, 4'd15);
    chk("t4_drop2", int'(drop_cnt), 2);
    offer(1, 4'd7);
    chk("t4_cmd7", int'(lcd_cmd), 7);
    chk("t4_grant1", int'(grant_id), 1);
    tick();
    chk("t4_issued", int'(issued_cnt), 1);
    repeat (8) tick();

    // busy never rises: timeout after BTO cycles, then recovery
    do_reset();
    busy_len = 0;
    offer(0, 4'd4);
    k = 0;
    while (!timeout_err && k < 100) begin tick(); k++; end
    chk("t5_timeout_latency", k, 16);
    busy_len = 2;
    offer(1, 4'd2);
    chk("t5_sticky", int'(timeout_err), 1);
    tick();
    chk("t5_issued", int'(issued_cnt), 2);
    repeat (8) tick();

    // WRITE wins the tie and locks out the pending requester
    do_reset();
    busy_len = 3;
    req1_valid = 1'b1; req1_cmd = 4'd6;
    r1b = r1_seen;
    offer(0, 4'd0);
    chk("t6_write_strobe", int'(lcd_cmd_valid), 1);
    repeat (10) tick();
    chk("t6_not_done_yet", int'(all_done), 0);
    lcd_done = 1'b1;
    tick();
    lcd_done = 1'b0;
    repeat (5) tick();
    chk("t6_all_done", int'(all_done), 1);
    chk("t6_req1_never_ready", r1_seen - r1b, 0);
    chk("t6_issued", int'(issued_cnt), 1);
    reset = 1'b0;
    #1;
    chk("t6_rst_all_done", int'(all_done), 0);
    chk("t6_rst_issued", int'(issued_cnt), 0);
    chk("t6_rst_ready1", int'(req1_ready), 0);
    req1_valid = 1'b0;

    // reset asserted while the issue strobe is high
    tick();
    reset = 1'b1;
    repeat (3) tick();
    offer(0, 4'd9);
    chk("t7_strobe_before", int'(lcd_cmd_valid), 1);
    #2 reset = 1'b0;
    #1;
    chk("t7_strobe_cleared", int'(lcd_cmd_valid), 0);
    chk("t7_cmd_cleared", int'(lcd_cmd), 0);
    tick();

    // drop counter saturation
    do_reset();
    req0_valid = 1'b1; req0_cmd = 4'd14;
    repeat (262) tick();
    req0_valid = 1'b0;
    tick();
    chk("t8_drop_sat", int'(drop_cnt), MAXC);
    chk("t8_no_issue", int'(issued_cnt), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
